// File: rtl/pulse_burst_pkg.sv
// Shared types and helpers for the pulse burst generator.
package pulse_burst_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] min4(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/burst_gap_timer.sv
// Loadable down-counter timing the low gap between burst pulses.
// expire is high while the count sits at 1, i.e. in the last gap cycle.
module burst_gap_timer
    import pulse_burst_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expire = (count == CNT_W'(1));

endmodule

// File: rtl/pulse_burst_gen.sv
// Emits a burst of single-cycle pulses on x_out for the decade pulse counter.
// Optional PULSE_BURST_LAST_EN adds a registered 'last' flag on the final pulse.
module pulse_burst_gen
    import pulse_burst_pkg::*;
#(
    parameter int MAX_COUNT  = 10,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] count_in,
    input  logic             abort,
    output logic             x_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
`ifdef PULSE_BURST_LAST_EN
    ,
    output logic             last
`endif
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES);

    state_t           state;
    logic [CNT_W-1:0] req_cnt;
    logic             gap_load;
    logic             gap_clear;
    logic             gap_expire;

    assign req_cnt   = min4(count_in, MAX_CNT);
    assign gap_load  = (state == PULSE) && !abort && (remaining != CNT_W'(1));
    assign gap_clear = abort && (state != IDLE);

    burst_gap_timer u_gap (
        .clock    (clock),
        .reset    (reset),
        .load     (gap_load),
        .clear    (gap_clear),
        .load_val (GAP_LD),
        .expire   (gap_expire)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            x_out     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
`ifdef PULSE_BURST_LAST_EN
            last      <= 1'b0;
`endif
        end else begin
            x_out <= 1'b0;
            done  <= 1'b0;
`ifdef PULSE_BURST_LAST_EN
            last  <= 1'b0;
`endif
            // Outputs are set for the state being entered, so they line up with it.
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (count_in != '0) begin
                            state     <= PULSE;
                            x_out     <= 1'b1;
                            remaining <= req_cnt;
`ifdef PULSE_BURST_LAST_EN
                            last      <= (req_cnt == CNT_W'(1));
`endif
                        end else begin
                            state     <= DONE;
                            done      <= 1'b1;
                            remaining <= '0;
                        end
                    end
                end
                PULSE: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        remaining <= '0;
                    end else if (remaining == CNT_W'(1)) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        remaining <= '0;
                    end else begin
                        state     <= GAP;
                        remaining <= remaining - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        remaining <= '0;
                    end else if (gap_expire) begin
                        state <= PULSE;
                        x_out <= 1'b1;
`ifdef PULSE_BURST_LAST_EN
                        last  <= (remaining == CNT_W'(1));
`endif
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    remaining <= '0;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    remaining <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Scoreboard bench for pulse_burst_gen: expected per-cycle outputs are queued
// when a burst is launched and compared on every falling edge.
module tb_pulse_burst_gen;

    localparam int MAXC = 10;
    localparam int GAPC = 1;

    logic       clock;
    logic       reset;
    logic       start;
    logic [3:0] count_in;
    logic       abort;
    logic       x_out;
    logic       busy;
    logic       done;
    logic [3:0] remaining;
`ifdef PULSE_BURST_LAST_EN
    logic       last;
`endif

    pulse_burst_gen #(
        .MAX_COUNT  (MAXC),
        .GAP_CYCLES (GAPC)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .count_in  (count_in),
        .abort     (abort),
        .x_out     (x_out),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
`ifdef PULSE_BURST_LAST_EN
        ,
        .last      (last)
`endif
    );

    typedef struct packed {
        logic       x;
        logic       d;
        logic       b;
        logic [3:0] r;
        logic       cr;
        logic       l;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b1;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t mk(input bit x, input bit d, input bit b,
                                input int r, input bit cr, input bit l);
        exp_t e;
        e.x  = x;
        e.d  = d;
        e.b  = b;
        e.r  = 4'(r);
        e.cr = cr;
        e.l  = l;
        return e;
    endfunction

    // Empty queue means the generator must be sitting idle.
    always @(negedge clock) begin
        if (mon_en) begin
            exp_t e;
            if (q.size() != 0) e = q.pop_front();
            else               e = mk(0, 0, 0, 0, 1, 0);
            check("x_out", 32'(x_out), 32'(e.x));
            check("done",  32'(done),  32'(e.d));
            check("busy",  32'(busy),  32'(e.b));
            if (e.cr) check("remaining", 32'(remaining), 32'(e.r));
`ifdef PULSE_BURST_LAST_EN
            check("last", 32'(last), 32'(e.l));
`endif
        end
    end

    task automatic drain();
        int guard = 0;
        while (q.size() != 0 && guard < 300) begin
            @(negedge clock);
            #1;
            guard++;
        end
        check("drain", 32'(q.size()), 32'd0);
    endtask

    task automatic run_burst(input int n, input int abort_after, input bit noise);
        int ne;
        @(posedge clock); #1;
        start    = 1'b1;
        count_in = 4'(n);
        @(posedge clock); #1;
        start    = 1'b0;
        count_in = 4'd0;
        ne = (n > MAXC) ? MAXC : n;
        if (ne == 0) begin
            q.push_back(mk(0, 1, 1, 0, 1, 0));
        end else begin
            for (int i = 1; i <= ne; i++) begin
                q.push_back(mk(1, 0, 1, ne - i + 1, 1, i == ne));
                if (abort_after == i) begin
                    q.push_back(mk(0, 0, 1, 0, 0, 0));
                    break;
                end
                if (i < ne) begin
                    for (int g = 0; g < GAPC; g++) q.push_back(mk(0, 0, 1, 0, 0, 0));
                end else begin
                    q.push_back(mk(0, 1, 1, 0, 1, 0));
                end
            end
        end
        if (abort_after > 0) begin
            repeat (1 + (abort_after - 1) * (GAPC + 1)) @(posedge clock);
            #1 abort = 1'b1;
            @(posedge clock);
            #1 abort = 1'b0;
        end
        if (noise) begin
            @(posedge clock);
            #1;
            start    = 1'b1;
            count_in = 4'd7;
            repeat (3) @(posedge clock);
            #1;
            start    = 1'b0;
            count_in = 4'd0;
        end
        drain();
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b1;
        count_in = 4'd3;
        abort    = 1'b0;
        repeat (3) @(posedge clock);
        #1 start = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);

        run_burst(3, 0, 0);
        run_burst(12, 0, 0);
        run_burst(0, 0, 0);
        run_burst(5, 2, 0);
        run_burst(2, 0, 0);
        run_burst(4, 0, 1);
        run_burst(1, 0, 0);

        // Asynchronous reset while pulse 2 of a 5-pulse burst is on x_out.
        @(posedge clock); #1;
        start    = 1'b1;
        count_in = 4'd5;
        @(posedge clock); #1;
        start    = 1'b0;
        count_in = 4'd0;
        q.push_back(mk(1, 0, 1, 5, 1, 0));
        for (int g = 0; g < GAPC; g++) q.push_back(mk(0, 0, 1, 0, 0, 0));
        q.push_back(mk(1, 0, 1, 4, 1, 0));
        drain();
        reset = 1'b0;
        #1;
        check("rst_x_out", 32'(x_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_remaining", 32'(remaining), 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        repeat (5) @(posedge clock);
        run_burst(2, 0, 0);
        repeat (2) @(posedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, failures so far %0d", n_fail);
        $fatal(1);
    end

endmodule
